// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word load handshake.
// A new word may be accepted during the last bit so consecutive words stream with no gap.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       load,
  output logic                       ready,
  output logic                       q,
  output logic                       q_valid,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             q_r;
  logic             last;
  logic             accept;

  // Handshake: a word is taken on any posedge where load && ready.
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign accept = load && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == IDLE) || last;
    q_valid = (state == SHIFT);
    done    = last;
    bit_cnt = cnt;
    q       = q_r;
  end

  // q_r holds the bit on the wire; sreg keeps that bit at its outgoing end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      q_r  <= 1'b0;
    end else if (accept) begin
      sreg <= din;
      cnt  <= '0;
      q_r  <= MSB_FIRST ? din[WIDTH-1] : din[0];
    end else if (state == SHIFT && !last) begin
      sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      q_r  <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
      cnt  <= cnt + CW'(1);
    end else if (last) begin
      sreg <= '0;
      cnt  <= '0;
      q_r  <= 1'b0;
    end
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 The port list SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  parallel word to serialize.
- load  input  1  word-valid strobe; accepted only when ready=1.
- ready  output  1  block can accept a word at the current edge.
- q  output  1  serial data bit (registered).
- q_valid  output  1  q carries a valid frame bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a word.
- bit_cnt  output  clog2(WIDTH)  index of the bit currently on q (0 = first bit).

Function
REQ-004 The block SHALL implement a two-state machine, IDLE and SHIFT.
REQ-005 In IDLE: ready=1, q=0, q_valid=0, done=0, bit_cnt=0.
REQ-006 Handshake: a word SHALL be accepted on a posedge where load=1 and ready=1; din is captured into an internal shift register at that edge.
REQ-007 Acceptance in IDLE SHALL move the FSM to SHIFT; the first bit SHALL appear on q, with q_valid=1 and bit_cnt=0, in the cycle immediately after the accepting edge (latency 1).
REQ-008 In SHIFT, each posedge SHALL advance to the next bit and increment bit_cnt; q_valid SHALL stay high for exactly WIDTH consecutive cycles per word.
REQ-009 Bit order SHALL follow MSB_FIRST: with MSB_FIRST=1 the word din[WIDTH-1]..din[0] is emitted in that order, matching a left-shifting serial-in receiver that inserts at bit 0.
REQ-010 done SHALL be 1 only in the cycle in which bit_cnt=WIDTH-1 and q_valid=1.
REQ-011 In SHIFT, ready SHALL be 0, except in the last-bit cycle (bit_cnt=WIDTH-1), where ready=1.
REQ-012 A load accepted in the last-bit cycle SHALL start the next word with no gap: the next cycle carries bit 0 of the new word, q_valid stays 1, and the FSM remains in SHIFT.
REQ-013 If no load is accepted in the last-bit cycle, the FSM SHALL return to IDLE, and the next cycle SHALL have q_valid=0 and q=0.
REQ-014 load while ready=0 SHALL be ignored, with no effect on the shift register, counter or outputs; din is don't-care whenever it is not being accepted.
REQ-015 bit_cnt SHALL wrap from WIDTH-1 to 0 only by the new-word or return-to-IDLE path; it SHALL never exceed WIDTH-1.

Reset
REQ-016 rst=1 SHALL asynchronously force: FSM=IDLE, shift register all zeros, bit_cnt=0, q=0, q_valid=0, done=0, ready=1.
REQ-017 Reset asserted mid-word SHALL abort the word with no further bits emitted; the partial word is discarded.
REQ-018 On the first posedge after rst deasserts, the block SHALL accept a load as in REQ-006.

Verification
REQ-019 The bench SHALL cover these directed scenarios (WIDTH=4 unless stated):
- Single word: load din=4'b1011 at edge 0 -> cycles 1..4 show q=1,0,1,1, q_valid=1, bit_cnt=0..3, done=1 in cycle 4 only; cycle 5 shows q_valid=0, ready=1.
- Back-to-back: 4'b1011 then 4'b0110 loaded in the last-bit cycle -> 8 contiguous q_valid cycles with q=1,0,1,1,0,1,1,0; done in cycles 4 and 8; a serial-in receiver captures 1011 then 0110.
- Ignored load: 4'b1011 in flight, load=1 with din=4'b0000 at bit_cnt=1 -> stream unchanged (1,0,1,1); ready=0 at bit_cnt 0..2.
- Reset mid-word: assert rst during bit_cnt=2 -> q, q_valid, done go to 0 immediately and ready=1; after release, load 4'b1100 -> q=1,1,0,0.
- LSB-first: MSB_FIRST=0, din=4'b1011 -> q=1,1,0,1.
- Width sweep: WIDTH=8, din=8'hA5, MSB_FIRST=1 -> q=1,0,1,0,0,1,0,1 over 8 cycles, done on the 8th cycle.
